rr_onehot_arbiter: RTL and testbench

//   Round-robin arbiter that shares one downstream resource between N requesters.

---
 rtl/rr_onehot_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_rr_onehot_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rr_onehot_arbiter.sv
// -----------------------------------------------------------------------------
// rr_onehot_arbiter
//   Round-robin arbiter that shares one downstream resource between N
//   requesters. The grant is registered and is given both as a one-hot vector
//   (for a mux select) and as a binary index (for a decoder). A requester holds
//   req until it is served and then pulses done. Every grant is followed by a
//   mandatory one-cycle idle gap, so grants are never back-to-back.
//
//   Parameters:
//     N        number of requesters (2..16, need not be a power of 2)
//     IDX_W    width of gnt_idx, must equal $clog2(N)
//     TIMEOUT  maximum grant length in cycles (only with ARB_TIMEOUT_EN)
//
//   Ports:
//     clk        in   1      clock, all logic on posedge
//     rst        in   1      synchronous, active-high reset
//     req        in   N      level request per requester, held until served
//     done       in   1      current owner finished (1-cycle pulse)
//     gnt        out  N      one-hot grant, registered
//     gnt_idx    out  IDX_W  binary index of the owner (holds the last owner)
//     gnt_valid  out  1      high while a grant is active (== |gnt)
//     timeout_o  out  1      1-cycle pulse in the idle cycle that follows a
//                            forced release
//
//   Optional feature (compile-time macro):
//     ARB_TIMEOUT_EN  when defined, a grant that lasts TIMEOUT cycles without
//                     a release is forcibly released. When undefined there is
//                     no timer and timeout_o is tied low.
// -----------------------------------------------------------------------------
module rr_onehot_arbiter #(
    parameter int N       = 4,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout_o
);

    if ((IDX_W != $clog2(N)) || (N < 2) || (N > 16) || (TIMEOUT < 1)) begin : g_param_err
        $error("rr_onehot_arbiter: illegal parameter combination");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic             owner_rel;
    logic             force_rel;
    logic             rel;

    // Winner search: walk candidates starting at ptr and wrapping at N-1.
    // The candidate is advanced explicitly instead of using a modulo so that
    // non-power-of-2 N wraps correctly.
    always_comb begin
        logic [IDX_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = ptr_q;
        for (int i = 0; i < N; i++) begin
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
            cand = (cand == IDX_W'(N - 1)) ? '0 : cand + IDX_W'(1);
        end
    end

    // Owner release: done pulse, or the owner dropped its request. Masking req
    // with the one-hot grant avoids indexing req with gnt_idx.
    assign owner_rel = done | ~|(req & gnt_q);
    assign rel       = owner_rel | force_rel;

`ifdef ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] timer_q, timer_d;
    logic             timeout_q, timeout_d;

    // A normal release on the same cycle wins, so force only without one.
    assign force_rel = (state_q == GRANT) && !owner_rel &&
                       (timer_q == TMR_W'(TIMEOUT));

    // timer reads 1 during the first grant cycle and counts up from there.
    always_comb begin
        timer_d   = timer_q;
        timeout_d = force_rel;
        if (state_q == IDLE) begin
            timer_d = win_found ? TMR_W'(1) : '0;
        end else if (rel) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign force_rel = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // State register (with grant, index and pointer flops).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = GRANT;
            GRANT:   if (rel)       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / pointer logic. Non-owner request changes are not looked at in
    // GRANT; they are picked up by the search in the following IDLE cycle.
    always_comb begin
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d     = {{(N-1){1'b0}}, 1'b1} << win_idx;
                    gnt_idx_d = win_idx;
                end
            end
            GRANT: begin
                if (rel) begin
                    gnt_d = '0;
                    ptr_d = (gnt_idx_q == IDX_W'(N - 1)) ? '0
                                                         : gnt_idx_q + IDX_W'(1);
                end
            end
            default: begin
                gnt_d = '0;
            end
        endcase
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_onehot_arbiter
//   Directed-vector bench for rr_onehot_arbiter (N=4). Inputs are changed 1ns
//   after the rising edge and outputs are sampled at the same point, so every
//   check sees the registered result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_rr_onehot_arbiter;

    localparam int N       = 4;
    localparam int IDX_W   = 2;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic             done;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_onehot_arbiter #(
        .N       (N),
        .IDX_W   (IDX_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout_o (timeout_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] idx,
                           input logic to);
        chk({tag, ".gnt"},       32'(gnt),       32'(g));
        chk({tag, ".gnt_idx"},   32'(gnt_idx),   32'(idx));
        chk({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(|g));
        chk({tag, ".timeout_o"}, 32'(timeout_o), 32'(to));
    endtask

    // Current cycle is the first cycle of a grant to g/idx. Hold one cycle,
    // pulse done in the second grant cycle, check the idle gap, then step into
    // the next grant cycle.
    task automatic serve(input string tag, input logic [3:0] g, input logic [1:0] idx);
        chk_out({tag, ".first"}, g, idx, 1'b0);
        tick();
        chk_out({tag, ".hold"}, g, idx, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk_out({tag, ".gap"}, 4'b0000, idx, 1'b0);
        tick();
    endtask

    task automatic do_reset(input logic [3:0] r);
        rst = 1'b1;
        req = r;
        done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] g2 [5];
        logic [1:0] i2 [5];
        logic [3:0] g3 [3];
        logic [1:0] i3 [3];
        g2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        i2 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        g3 = '{4'b0010, 4'b1000, 4'b0010};
        i3 = '{2'd1, 2'd3, 2'd1};

        // 1: reset held two cycles with all requests up
        rst  = 1'b1;
        req  = 4'b1111;
        done = 1'b0;
        tick();
        chk_out("t1.rst0", 4'b0000, 2'd0, 1'b0);
        tick();
        chk_out("t1.rst1", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("t1.first", 4'b0001, 2'd0, 1'b0);

        // 2: full rotation with wrap back to requester 0
        for (int k = 0; k < 5; k++) serve($sformatf("t2.%0d", k), g2[k], i2[k]);

        // 3: sparse requests 1010
        do_reset(4'b1010);
        chk_out("t3.rst", 4'b0000, 2'd0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) serve($sformatf("t3.%0d", k), g3[k], i3[k]);

        // 4: owner drops req, done in IDLE, non-owner changes during GRANT
        do_reset(4'b0100);
        tick();
        chk_out("t4.own2", 4'b0100, 2'd2, 1'b0);
        req = 4'b0000;
        tick();
        chk_out("t4.drop", 4'b0000, 2'd2, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk_out("t4.idle_done", 4'b0000, 2'd2, 1'b0);
        req = 4'b1001;
        tick();
        chk_out("t4.ptr3", 4'b1000, 2'd3, 1'b0);
        req = 4'b1111;
        tick();
        chk_out("t4.nonowner", 4'b1000, 2'd3, 1'b0);
        req = 4'b0111;
        tick();
        chk_out("t4.drop3", 4'b0000, 2'd3, 1'b0);
        req = 4'b1111;
        tick();
        chk_out("t4.wrap", 4'b0001, 2'd0, 1'b0);

        // 5: reset in the middle of a grant to requester 2
        do_reset(4'b1111);
        tick();
        serve("t5.a", 4'b0001, 2'd0);
        serve("t5.b", 4'b0010, 2'd1);
        chk_out("t5.own2", 4'b0100, 2'd2, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_out("t5.rst", 4'b0000, 2'd0, 1'b0);
        tick();
        chk_out("t5.after", 4'b0001, 2'd0, 1'b0);

        // 6: single requester holding req with no done
        do_reset(4'b0001);
        tick();
        chk_out("t6.c1", 4'b0001, 2'd0, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int c = 2; c <= TIMEOUT; c++) begin
            tick();
            chk_out($sformatf("t6.c%0d", c), 4'b0001, 2'd0, 1'b0);
        end
        tick();
        chk_out("t6.forced", 4'b0000, 2'd0, 1'b1);
        tick();
        chk_out("t6.regrant", 4'b0001, 2'd0, 1'b0);
        for (int c = 2; c <= TIMEOUT; c++) begin
            tick();
            chk_out($sformatf("t6.r%0d", c), 4'b0001, 2'd0, 1'b0);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        chk_out("t6.done_wins", 4'b0000, 2'd0, 1'b0);
`else
        for (int c = 2; c <= 100; c++) begin
            tick();
            chk_out($sformatf("t6.c%0d", c), 4'b0001, 2'd0, 1'b0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
